// File: rtl/chord_pkg.sv
// rtl/chord_pkg.sv - shared constants for the CORDIC input/output interfaces
package chord_pkg;

   localparam int DATA_WIDTH_DFLT = 16;
   localparam int OUT_WIDTH_DFLT  = 32;

   // Q7.8 fixed point: 1.0 and the +/-90 degree fold boundaries
   localparam logic [15:0] ONE       = 16'h0100;
   localparam logic [15:0] ANGLE_P90 = 16'h5A00;
   localparam logic [15:0] ANGLE_N90 = 16'hA600;

   localparam int COS_MSB  = 31;
   localparam int SIN_MSB  = 15;
   localparam int MODE_BIT = 16;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO with show-ahead read and extra-bit pointers
module result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same cycle, so a full FIFO can still accept
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign count   = wr_ptr - rd_ptr;
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/interface_output.sv
// rtl/interface_output.sv - CORDIC result fold correction, packing and output FIFO
module interface_output
   import chord_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DFLT,
   parameter int FLIP_FLAG_WIDTH = 1,
   parameter int FIFO_DEPTH      = 4,
   parameter int OUT_WIDTH       = OUT_WIDTH_DFLT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           valid_out,
   input  logic [DATA_WIDTH-1:0]          sin_out,
   input  logic [DATA_WIDTH-1:0]          cos_out,
   input  logic [DATA_WIDTH-1:0]          angle_out,
   input  logic [FLIP_FLAG_WIDTH-1:0]     flip_out,
   input  logic                           arctan_en_out,
   output logic [OUT_WIDTH-1:0]           res_data,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [$clog2(FIFO_DEPTH):0]    res_count,
   output logic                           ovf,
   input  logic                           ovf_clr
);

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
      return (v == MOST_NEG) ? ~MOST_NEG : -v;
   endfunction

   logic [DATA_WIDTH-1:0] sin_fix;
   logic [DATA_WIDTH-1:0] cos_fix;
   logic [OUT_WIDTH-1:0]  word_next;
   logic [OUT_WIDTH-1:0]  s1_word;
   logic                  s1_valid;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_drop;

   // Undo the input fold: rotate by +/-90 degrees, direction from the folded sine sign
   always_comb begin
      sin_fix = sin_out;
      cos_fix = cos_out;
      if (flip_out[0]) begin
         if (!sin_out[DATA_WIDTH-1]) begin
            sin_fix = cos_out;
            cos_fix = sat_neg(sin_out);
         end else begin
            sin_fix = sat_neg(cos_out);
            cos_fix = sin_out;
         end
      end
   end

   always_comb begin
      word_next = '0;
      if (arctan_en_out) begin
         word_next[MODE_BIT]          = 1'b1;
         word_next[DATA_WIDTH-1:0]    = angle_out;
      end else begin
         word_next[COS_MSB -: DATA_WIDTH] = cos_fix;
         word_next[SIN_MSB -: DATA_WIDTH] = sin_fix;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
      end else begin
         s1_valid <= valid_out;
         if (valid_out) s1_word <= word_next;
      end
   end

   result_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s1_valid),
      .push_data (s1_word),
      .pop       (res_ready),
      .rd_data   (res_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (res_count),
      .drop      (fifo_drop)
   );

   assign res_valid = ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            ovf <= 1'b0;
      else if (fifo_drop) ovf <= 1'b1;
      else if (ovf_clr)   ovf <= 1'b0;
   end

endmodule

// File: tb/tb_interface_output.sv
// tb/tb_interface_output.sv - scoreboard bench for interface_output
module tb_interface_output;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_out = 1'b0;
   logic [15:0] sin_out = '0;
   logic [15:0] cos_out = '0;
   logic [15:0] angle_out = '0;
   logic [0:0]  flip_out = '0;
   logic        arctan_en_out = 1'b0;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [2:0]  res_count;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] first_word;

   always #5 clk = ~clk;

   interface_output dut (
      .clk           (clk),
      .rst           (rst),
      .valid_out     (valid_out),
      .sin_out       (sin_out),
      .cos_out       (cos_out),
      .angle_out     (angle_out),
      .flip_out      (flip_out),
      .arctan_en_out (arctan_en_out),
      .res_data      (res_data),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_count     (res_count),
      .ovf           (ovf),
      .ovf_clr       (ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] neg_sat(input logic [15:0] v);
      if (v == 16'h8000) return 16'h7FFF;
      return 16'h0000 - v;
   endfunction

   function automatic logic [31:0] model(input logic [15:0] s, input logic [15:0] c,
                                         input logic [15:0] a, input logic f, input logic arc);
      if (arc) return {15'd0, 1'b1, a};
      if (!f) return {c, s};
      if (!s[15]) return {neg_sat(s), c};
      return {s, neg_sat(c)};
   endfunction

   // Scoreboard: every accepted pop is compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got %h expected no word", res_data);
         end else begin
            check("sb_data", res_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] s, input logic [15:0] c, input logic [15:0] a,
                       input logic f, input logic arc);
      sin_out = s; cos_out = c; angle_out = a; flip_out = f; arctan_en_out = arc;
      valid_out = 1'b1;
      @(posedge clk); #1;
      valid_out = 1'b0;
   endtask

   task automatic drain();
      int n;
      res_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      res_ready = 1'b0;
      @(negedge clk);
      check("drain_empty", {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      logic [15:0] rs, rc, ra;
      logic        rf, rarc;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_data", res_data, 32'd0);
      check("rst_count", {29'd0, res_count}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Latency: valid in N, res_valid in N+2
      send(16'h0080, 16'h00DD, 16'h0, 1'b0, 1'b0);
      exp_q.push_back(32'h00DD0080);
      @(negedge clk);
      check("lat_n1_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_n2_valid", {31'd0, res_valid}, 32'd1);
      check("lat_n2_data", res_data, 32'h00DD0080);
      check("lat_n2_count", {29'd0, res_count}, 32'd1);
      @(posedge clk); #1;
      drain();

      // Directed fold, arctan and saturation cases at full rate
      @(posedge clk); #1;
      res_ready = 1'b1;
      send(16'h0080, 16'h00DD, 16'h0, 1'b1, 1'b0); exp_q.push_back(32'hFF8000DD);
      send(16'hFF23, 16'h0080, 16'h0, 1'b1, 1'b0); exp_q.push_back(32'hFF23FF80);
      send(16'h1234, 16'h5678, 16'h2D00, 1'b1, 1'b1); exp_q.push_back(32'h00012D00);
      send(16'h0000, 16'h8000, 16'h0, 1'b1, 1'b0); exp_q.push_back(32'h00008000);
      send(16'h8000, 16'h8000, 16'h0, 1'b1, 1'b0); exp_q.push_back(32'h80007FFF);
      drain();

      // Overflow: 6 samples into a stalled FIFO, last two dropped
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         rs = 16'($urandom); rc = 16'($urandom); ra = 16'($urandom);
         rf = 1'($urandom); rarc = 1'($urandom);
         if (i == 0) first_word = model(rs, rc, ra, rf, rarc);
         if (i < 4) exp_q.push_back(model(rs, rc, ra, rf, rarc));
         send(rs, rc, ra, rf, rarc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("ovf_count", {29'd0, res_count}, 32'd4);
      check("ovf_flag", {31'd0, ovf}, 32'd1);
      check("ovf_head", res_data, first_word);
      @(posedge clk); #1;
      drain();
      check("ovf_sticky", {31'd0, ovf}, 32'd1);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", {31'd0, ovf}, 32'd0);

      // Full FIFO: write and pop in the same cycle are both accepted
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         rs = 16'($urandom); rc = 16'($urandom);
         exp_q.push_back(model(rs, rc, 16'h0, 1'b0, 1'b0));
         send(rs, rc, 16'h0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      rs = 16'($urandom); rc = 16'($urandom);
      exp_q.push_back(model(rs, rc, 16'h0, 1'b1, 1'b0));
      send(rs, rc, 16'h0, 1'b1, 1'b0);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("full_pp_count", {29'd0, res_count}, 32'd4);
      check("full_pp_ovf", {31'd0, ovf}, 32'd0);
      @(posedge clk); #1;
      drain();

      // Sustained full rate with random data, no drops
      @(posedge clk); #1;
      res_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         rs = 16'($urandom); rc = 16'($urandom); ra = 16'($urandom);
         rf = 1'($urandom); rarc = 1'($urandom);
         exp_q.push_back(model(rs, rc, ra, rf, rarc));
         send(rs, rc, ra, rf, rarc);
      end
      drain();
      check("rate_ovf", {31'd0, ovf}, 32'd0);

      // Asynchronous reset with 3 entries held
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         rs = 16'($urandom); rc = 16'($urandom);
         exp_q.push_back(model(rs, rc, 16'h0, 1'b0, 1'b0));
         send(rs, rc, 16'h0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_count", {29'd0, res_count}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", {31'd0, res_valid}, 32'd0);
      check("arst_count", {29'd0, res_count}, 32'd0);
      check("arst_data", res_data, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("post_rst_valid", {31'd0, res_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
